// File: rtl/sr_bank_arbiter_if.sv
// Request/strobe bundle between requesters and the SR flip-flop bank arbiter.
// The err signal exists only when SR_IDX_CHECK_EN is defined.
interface sr_bank_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned N_BITS = 8
);
    localparam int unsigned IW = $clog2(N_BITS);

    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    op;
    logic [N_REQ*IW-1:0] idx;
    logic [N_BITS-1:0]   s_vec;
    logic [N_BITS-1:0]   r_vec;
    logic [N_REQ-1:0]    grant;
    logic                busy;
`ifdef SR_IDX_CHECK_EN
    logic                err;

    modport master (output req, op, idx, input s_vec, r_vec, grant, busy, err);
    modport slave  (input req, op, idx, output s_vec, r_vec, grant, busy, err);
`else
    modport master (output req, op, idx, input s_vec, r_vec, grant, busy);
    modport slave  (input req, op, idx, output s_vec, r_vec, grant, busy);
`endif
endinterface

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter giving N_REQ requesters one-cycle set/reset strobes into an SR bank.
// Define SR_IDX_CHECK_EN to add the err output flagging out-of-range bit indices.
module sr_bank_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned N_BITS = 8
) (
    input logic              clk,
    input logic              rst_n,
    sr_bank_arbiter_if.slave bus
);
    localparam int unsigned IW = $clog2(N_BITS);
    localparam int unsigned PW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StDrive = 2'b01,
        StAck   = 2'b10
    } state_e;

    state_e            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win;
    logic [N_BITS-1:0] s_q;
    logic [N_BITS-1:0] r_q;
    logic [N_REQ-1:0]  grant_q;

    logic [PW-1:0]     pick;
    logic [IW-1:0]     pick_idx;
    logic [N_BITS-1:0] pick_dec;

    // First requester at or above ptr, wrapping around.
    function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [PW-1:0]    p);
        logic [PW-1:0] sel;
        logic [PW-1:0] cand;
        logic          found;
        sel   = p;
        found = 1'b0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = PW'((32'(p) + off) % N_REQ);
            if (!found && r[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Indices at or beyond N_BITS decode to no strobe at all.
    function automatic logic [N_BITS-1:0] decode(input logic [IW-1:0] ix);
        logic [N_BITS-1:0] v;
        for (int unsigned b = 0; b < N_BITS; b++) begin
            v[b] = (ix == IW'(b));
        end
        return v;
    endfunction

    always_comb begin
        pick     = rr_pick(bus.req, ptr);
        pick_idx = bus.idx[pick*IW +: IW];
        pick_dec = decode(pick_idx);
    end

`ifdef SR_IDX_CHECK_EN
    logic [IW-1:0] idx_l;
    logic          err_q;
    assign bus.err = err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            ptr     <= '0;
            win     <= '0;
            s_q     <= '0;
            r_q     <= '0;
            grant_q <= '0;
`ifdef SR_IDX_CHECK_EN
            idx_l   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    s_q     <= '0;
                    r_q     <= '0;
                    grant_q <= '0;
                    if (|bus.req) begin
                        state <= StDrive;
                        win   <= pick;
                        // Strobe registers double as the latched op/idx of the winner.
                        if (bus.op[pick]) begin
                            s_q <= pick_dec;
                        end else begin
                            r_q <= pick_dec;
                        end
`ifdef SR_IDX_CHECK_EN
                        idx_l <= pick_idx;
`endif
                    end
                end
                StDrive: begin
                    s_q     <= '0;
                    r_q     <= '0;
                    grant_q <= N_REQ'(1) << win;
`ifdef SR_IDX_CHECK_EN
                    err_q   <= (32'(idx_l) >= N_BITS);
`endif
                    state   <= StAck;
                end
                StAck: begin
                    grant_q <= '0;
`ifdef SR_IDX_CHECK_EN
                    err_q   <= 1'b0;
`endif
                    ptr     <= (32'(win) == N_REQ - 1) ? '0 : win + 1'b1;
                    state   <= StIdle;
                end
                default: begin
                    s_q     <= '0;
                    r_q     <= '0;
                    grant_q <= '0;
`ifdef SR_IDX_CHECK_EN
                    err_q   <= 1'b0;
`endif
                    state   <= StIdle;
                end
            endcase
        end
    end

    assign bus.s_vec = s_q;
    assign bus.r_vec = r_q;
    assign bus.grant = grant_q;
    assign bus.busy  = (state != StIdle);

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Scoreboard bench for sr_bank_arbiter: driver predicts each transaction, monitor checks outputs.
// Works with or without SR_IDX_CHECK_EN defined.
module tb_sr_bank_arbiter;
    localparam int NR = 4;
    localparam int NB = 6;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sr_bank_arbiter_if #(.N_REQ(NR), .N_BITS(NB)) bus ();

    sr_bank_arbiter #(.N_REQ(NR), .N_BITS(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [NR-1:0] g;
        logic [NB-1:0] s;
        logic [NB-1:0] r;
        logic          e;
        int            arb;
    } exp_t;

    exp_t          sb[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            m_ptr   = 0;
    int            m_hold  = 0;
    logic [NB-1:0] bank;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            assert ((bus.s_vec & bus.r_vec) == '0)
            else $error("s_vec and r_vec overlap: %b %b", bus.s_vec, bus.r_vec);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs and applies the arbitration rules to predict the outcome.
    task automatic drive(input logic [NR-1:0] r, input logic [NR-1:0] o,
                         input logic [NR*IW-1:0] ix);
        exp_t e;
        int   w;
        int   ti;
        @(negedge clk);
        #1;
        bus.req = r;
        bus.op  = o;
        bus.idx = ix;
        if (m_hold > 0) begin
            m_hold--;
        end else if (r != '0) begin
            w = -1;
            for (int k = 0; k < NR; k++) begin
                if (w < 0 && r[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
            end
            ti    = int'(ix[w*IW +: IW]);
            e.g   = NR'(1) << w;
            e.s   = (o[w] && ti < NB) ? NB'(1) << ti : '0;
            e.r   = (!o[w] && ti < NB) ? NB'(1) << ti : '0;
            e.e   = (ti >= NB);
            e.arb = cyc + 1;
            sb.push_back(e);
            m_ptr  = (w + 1) % NR;
            m_hold = 2;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n   = 1'b0;
        bus.req = '0;
        bus.op  = '0;
        bus.idx = '0;
        sb.delete();
        m_ptr  = 0;
        m_hold = 0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pairs each strobe with the grant that follows it and checks both.
    initial begin : monitor
        exp_t          e;
        logic          pend;
        logic [NB-1:0] ps;
        logic [NB-1:0] pr;
        pend = 1'b0;
        ps   = '0;
        pr   = '0;
        bank = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                check("s_and_r_overlap", 32'(bus.s_vec & bus.r_vec), 0);
                for (int b = 0; b < NB; b++) begin
                    if (bus.s_vec[b]) bank[b] = 1'b1;
                    if (bus.r_vec[b]) bank[b] = 1'b0;
                end
                if (bus.grant != '0) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_grant: got 0x%0h, expected none", bus.grant);
                    end else begin
                        e = sb.pop_front();
                        check("grant", 32'(bus.grant), 32'(e.g));
                        check("grant_cycle", cyc, e.arb + 1);
                        check("s_strobe", pend ? 32'(ps) : 0, 32'(e.s));
                        check("r_strobe", pend ? 32'(pr) : 0, 32'(e.r));
`ifdef SR_IDX_CHECK_EN
                        check("err", 32'(bus.err), 32'(e.e));
`endif
                    end
                    pend = 1'b0;
                end else if (pend) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL missing_grant: got none after strobe s=0x%0h r=0x%0h",
                             ps, pr);
                    pend = 1'b0;
                end
                if ((bus.s_vec | bus.r_vec) != '0) begin
                    check("strobe_onehot", $countones(bus.s_vec | bus.r_vec), 1);
                    pend = 1'b1;
                    ps   = bus.s_vec;
                    pr   = bus.r_vec;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        logic [NR*IW-1:0] rix;
        rst_n   = 1'b0;
        bus.req = '0;
        bus.op  = '0;
        bus.idx = '0;
        repeat (2) @(negedge clk);
        check("rst_s_vec", 32'(bus.s_vec), 0);
        check("rst_r_vec", 32'(bus.r_vec), 0);
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_busy", 32'(bus.busy), 0);
`ifdef SR_IDX_CHECK_EN
        check("rst_err", 32'(bus.err), 0);
`endif
        #1;
        rst_n = 1'b1;
        idle(2);

        // Single set of bit 5 by requester 0.
        drive(4'b0001, 4'b0001, 12'd5);
        @(posedge clk);
        #1;
        check("single_s_vec", 32'(bus.s_vec), 32'h20);
        check("single_busy", 32'(bus.busy), 1);
        drive(4'b0001, 4'b0001, 12'd5);
        drive(4'b0001, 4'b0001, 12'd5);
        idle(4);

        // Round-robin with all requesters held, starting from ptr 0.
        do_reset();
        for (int i = 0; i < 13; i++) drive(4'b1111, 4'b1010, 12'o3210);
        idle(4);

        // Reset during the strobe cycle cancels the operation; ptr is left at 1 beforehand.
        drive(4'b0001, 4'b0001, 12'd5);
        @(posedge clk);
        #2;
        check("pre_rst_s_vec", 32'(bus.s_vec), 32'h20);
        rst_n = 1'b0;
        #1;
        check("async_rst_s_vec", 32'(bus.s_vec), 0);
        check("async_rst_busy", 32'(bus.busy), 0);
        check("async_rst_grant", 32'(bus.grant), 0);
        bus.req = '0;
        sb.delete();
        m_ptr  = 0;
        m_hold = 0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Same-bit contention: req0 sets bit 2, req1 resets it; req0 must win first.
        for (int i = 0; i < 6; i++) drive(4'b0011, 4'b0001, 12'o0022);
        idle(4);
        check("bank_bit2", 32'(bank[2]), 0);

        // Out-of-range indices 7 and 6 with N_BITS = 6.
        drive(4'b0001, 4'b0001, 12'd7);
        idle(4);
        drive(4'b0010, 4'b0000, 12'o0060);
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rix = 12'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                drive('0, 4'($urandom), rix);
            end else begin
                drive(4'($urandom), 4'($urandom), rix);
            end
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        idle(2);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sr_bank_arbiter.md
SR_BANK_ARBITER -- requirements
Module: sr_bank_arbiter

Interface
- REQ-001: Parameter N_REQ, default 4, meaning number of requesters sharing the SR flip-flop bank (2..8).
- REQ-002: Parameter N_BITS, default 8, meaning number of SR flip-flops in the controlled bank (2..16); IW = clog2(N_BITS).
- REQ-003: clk  input  1  single clock; all state changes on posedge clk.
- REQ-004: rst_n  input  1  asynchronous, active-low reset.
- REQ-005: req  input  N_REQ  per-requester request, level, held until grant.
- REQ-006: op  input  N_REQ  per-requester operation: 1 = set, 0 = reset.
- REQ-007: idx  input  N_REQ*IW  per-requester target bit index; requester i uses slice [i*IW +: IW].
- REQ-008: s_vec  output  N_BITS  set strobes to the bank's s inputs, registered.
- REQ-009: r_vec  output  N_BITS  reset strobes to the bank's r inputs, registered.
- REQ-010: grant  output  N_REQ  one-hot completion acknowledge, one-cycle pulse, registered.
- REQ-011: busy  output  1  high whenever the FSM is not in IDLE.

Function
- REQ-012: FSM states are IDLE, DRIVE and ACK, encoded in 2 bits; the unused encoding SHALL return to IDLE on the next edge.
- REQ-013: In IDLE with any req high, the arbiter SHALL choose a winner by round-robin, searching from pointer ptr upward with wrap, then latch the winner, op and idx, and go to DRIVE.
- REQ-014: In IDLE with no req high, the FSM SHALL stay in IDLE with s_vec, r_vec and grant all zero.
- REQ-015: In DRIVE, exactly one bit SHALL be high for exactly one cycle, s_vec[idx] if op=1 or r_vec[idx] if op=0; the FSM then goes to ACK.
- REQ-016: s_vec & r_vec SHALL be zero in every cycle; the illegal s=r=1 bank input is never produced.
- REQ-017: In ACK, grant[winner] SHALL be high for one cycle, ptr SHALL become (winner+1) mod N_REQ, and the FSM returns to IDLE.
- REQ-018: Latency: req high before edge k gives the strobe in cycle k+1 and grant in cycle k+2; one operation completes per 3 cycles.
- REQ-019: A requester dropping req after it has been latched SHALL NOT abort the operation; a req dropped while in IDLE is never latched.
- REQ-020: req, op and idx changes during DRIVE or ACK SHALL be ignored until the next IDLE.
- REQ-021: A requester holding req after its grant SHALL be treated as a new request, subject to round-robin.
- REQ-022: Two requesters targeting the same bit are serviced sequentially in round-robin order, so the last one granted determines the bit's value.

Reset
- REQ-023: On rst_n low, asynchronously: state = IDLE, ptr = 0, s_vec = 0, r_vec = 0, grant = 0, busy = 0, latched fields = 0.
- REQ-024: Reset asserted in DRIVE SHALL clear the strobe immediately; the operation is lost and no grant is issued.
- REQ-025: After rst_n rises, the first arbitration SHALL occur on the first posedge with req nonzero.

Configuration
- REQ-026: Macro SR_IDX_CHECK_EN, when defined, adds output err (1 bit, registered, reset 0) and checks the latched idx against N_BITS.
- REQ-027: With SR_IDX_CHECK_EN defined and latched idx >= N_BITS: DRIVE drives no strobe, and err pulses high alongside grant in ACK.
- REQ-028: Without SR_IDX_CHECK_EN: there is no err port and idx is used modulo 2^IW; out-of-range indices drive nothing.

Verification
- REQ-029: Single request: req=0001, op=1, idx0=5 -> s_vec=0x20 for one cycle, then grant=0001 for one cycle, with r_vec=0 throughout.
- REQ-030: Round-robin: req=1111 held, ptr=0 -> grants 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart.
- REQ-031: Same-bit contention: req0 sets bit 2 and req1 resets bit 2 together -> s_vec=0x04 first, then r_vec=0x04; a bank model shows q=0.
- REQ-032: Reset mid-DRIVE: rst_n low during the strobe cycle -> s_vec=0 asynchronously, no grant, and ptr=0 after release.
- REQ-033: Macro on, N_BITS=6, idx=7 -> no strobe, err=1 with grant; macro off with the same stimulus -> no strobe, and an assertion checks s_vec & r_vec == 0 in every cycle.
